// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-operand bundle between the issue sequencer, its
// instruction source, the external ALU and writeback.
interface alu_issue_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  inst_valid_i;
   logic                  inst_ready_o;
   logic [31:0]           inst_i;
   logic [DATA_WIDTH-1:0] rs1_data_i;
   logic [DATA_WIDTH-1:0] rs2_data_i;
   logic [2:0]            ALU_control_o;
   logic [DATA_WIDTH-1:0] data1_o;
   logic [DATA_WIDTH-1:0] data2_o;
   logic [DATA_WIDTH-1:0] result_i;
   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [DATA_WIDTH-1:0] result_o;
   logic [4:0]            rd_addr_o;
   logic                  illegal_o;

   modport slave (
      input  inst_valid_i, inst_i, rs1_data_i, rs2_data_i, result_i, res_ready_i,
      output inst_ready_o, ALU_control_o, data1_o, data2_o, res_valid_o,
             result_o, rd_addr_o, illegal_o
   );

   modport master (
      output inst_valid_i, inst_i, rs1_data_i, rs2_data_i, result_i, res_ready_i,
      input  inst_ready_o, ALU_control_o, data1_o, data2_o, res_valid_o,
             result_o, rd_addr_o, illegal_o
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for a 3-bit-control external ALU: decodes one RV32 ALU
// instruction at a time, holds operands for a fixed latency, hands result to writeback.
module alu_issue_ctrl #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int          MUL_LATENCY = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_issue_ctrl_if.slave  bus
);

   localparam int unsigned MUL_LAT = (MUL_LATENCY < 1) ? 1 : MUL_LATENCY;
   localparam int unsigned CNT_W   = $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_OR  = 3'b100,
      ALU_AND = 3'b101
   } alu_op_e;

   state_e                state_q, state_d;
   alu_op_e               ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d;
   logic [DATA_WIDTH-1:0] data2_q, data2_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [4:0]            rd_q, rd_d;
   logic                  illegal_q, illegal_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  dec_legal;
   logic                  dec_mul;
   logic                  dec_imm;
   alu_op_e               dec_ctrl;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic                  unused_rs1_field;

   assign opcode  = bus.inst_i[6:0];
   assign funct3  = bus.inst_i[14:12];
   assign funct7  = bus.inst_i[31:25];
   assign imm_ext = {{(DATA_WIDTH-12){bus.inst_i[31]}}, bus.inst_i[31:20]};
   // Register indices are resolved upstream; only operand values arrive here.
   assign unused_rs1_field = ^bus.inst_i[19:15];

   always_comb begin
      dec_legal = 1'b0;
      dec_mul   = 1'b0;
      dec_imm   = 1'b0;
      dec_ctrl  = ALU_ADD;
      case (opcode)
         7'b0110011: begin
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
               {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_ctrl = ALU_SUB; end
               {7'b0000001, 3'b000}: begin
                  dec_legal = 1'b1;
                  dec_ctrl  = ALU_MUL;
                  dec_mul   = 1'b1;
               end
               {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
               {7'b0000000, 3'b111}: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
               default: dec_legal = 1'b0;
            endcase
         end
         7'b0010011: begin
            dec_imm = 1'b1;
            case (funct3)
               3'b000:  begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
               3'b110:  begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
               3'b111:  begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         ctrl_q    <= ALU_ADD;
         data1_q   <= '0;
         data2_q   <= '0;
         result_q  <= '0;
         rd_q      <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         data1_q   <= data1_d;
         data2_q   <= data2_d;
         result_q  <= result_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.inst_valid_i && dec_legal) state_d = EXEC;
         EXEC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE:    if (bus.res_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      data1_d   = data1_q;
      data2_d   = data2_q;
      result_d  = result_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.inst_valid_i) begin
               if (dec_legal) begin
                  ctrl_d  = dec_ctrl;
                  data1_d = bus.rs1_data_i;
                  data2_d = dec_imm ? imm_ext : bus.rs2_data_i;
                  rd_d    = bus.inst_i[11:7];
                  cnt_d   = dec_mul ? CNT_W'(MUL_LAT) : CNT_W'(1);
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) result_d = bus.result_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.inst_ready_o  = (state_q == IDLE);
      bus.res_valid_o   = (state_q == DONE);
      bus.ALU_control_o = ctrl_q;
      bus.data1_o       = data1_q;
      bus.data2_o       = data2_q;
      bus.result_o      = result_q;
      bus.rd_addr_o     = rd_q;
      bus.illegal_o     = illegal_q;
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions push expected
// responses; a negedge monitor checks every presented result.
module tb_alu_issue_ctrl;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   logic prev_valid;

   typedef struct {
      int          cyc;
      logic [2:0]  ctrl;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];

   alu_issue_ctrl_if #(.DATA_WIDTH(32)) bus ();

   alu_issue_ctrl #(.DATA_WIDTH(32), .MUL_LATENCY(3)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural stand-in for the external combinational ALU.
   always_comb begin
      case (bus.ALU_control_o)
         3'b000:  bus.result_i = bus.data1_o + bus.data2_o;
         3'b001:  bus.result_i = bus.data1_o - bus.data2_o;
         3'b010:  bus.result_i = bus.data1_o * bus.data2_o;
         3'b100:  bus.result_i = bus.data1_o | bus.data2_o;
         3'b101:  bus.result_i = bus.data1_o & bus.data2_o;
         default: bus.result_i = 32'h0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (bus.res_valid_o) begin
            if (sb.size() == 0) begin
               chk("spurious_res_valid", 64'(bus.res_valid_o), 64'd0);
            end else begin
               if (!prev_valid) begin
                  chk("res_latency", 64'(cyc), 64'(sb[0].cyc));
                  chk("alu_ctrl", 64'(bus.ALU_control_o), 64'(sb[0].ctrl));
                  chk("data1", 64'(bus.data1_o), 64'(sb[0].d1));
                  chk("data2", 64'(bus.data2_o), 64'(sb[0].d2));
                  chk("rd_addr", 64'(bus.rd_addr_o), 64'(sb[0].rd));
                  chk("result", 64'(bus.result_o), 64'(sb[0].res));
               end else begin
                  chk("result_held", 64'(bus.result_o), 64'(sb[0].res));
                  chk("rd_held", 64'(bus.rd_addr_o), 64'(sb[0].rd));
               end
               if (bus.res_ready_i) void'(sb.pop_front());
            end
         end
         prev_valid <= bus.res_valid_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.inst_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) chk("inst_ready_timeout", 64'(bus.inst_ready_o), 64'd1);
   endtask

   task automatic issue(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [2:0] ctrl, input logic [31:0] d2, input logic [31:0] res,
                        input int lat, input int hold);
      exp_t e;
      int   n;
      wait_ready();
      e.cyc  = cyc + 1 + lat;
      e.ctrl = ctrl;
      e.d1   = rs1;
      e.d2   = d2;
      e.res  = res;
      e.rd   = inst[11:7];
      sb.push_back(e);
      bus.inst_valid_i = 1'b1;
      bus.inst_i       = inst;
      bus.rs1_data_i   = rs1;
      bus.rs2_data_i   = rs2;
      bus.res_ready_i  = (hold == 0);
      tick();
      bus.inst_valid_i = 1'b0;
      bus.rs1_data_i   = 32'hDEAD_BEEF;
      bus.rs2_data_i   = 32'hCAFE_F00D;
      n = 0;
      while (!bus.res_valid_o && n < 50) begin
         chk("exec_ctrl_stable", 64'(bus.ALU_control_o), 64'(ctrl));
         chk("exec_inst_ready", 64'(bus.inst_ready_o), 64'd0);
         tick();
         n++;
      end
      if (n == 50) begin
         chk("res_valid_timeout", 64'(bus.res_valid_o), 64'd1);
         sb.delete();
      end
      for (int i = 0; i < hold; i++) begin
         chk("done_inst_ready", 64'(bus.inst_ready_o), 64'd0);
         bus.inst_valid_i = 1'b1;
         bus.inst_i       = 32'h002081B3;
         tick();
      end
      bus.inst_valid_i = 1'b0;
      bus.res_ready_i  = 1'b1;
      tick();
      chk("post_accept_valid", 64'(bus.res_valid_o), 64'd0);
      chk("post_accept_ready", 64'(bus.inst_ready_o), 64'd1);
   endtask

   task automatic issue_illegal(input logic [31:0] inst);
      logic [2:0]  ctrl0;
      logic [31:0] d1_0;
      wait_ready();
      ctrl0 = bus.ALU_control_o;
      d1_0  = bus.data1_o;
      bus.inst_valid_i = 1'b1;
      bus.inst_i       = inst;
      bus.rs1_data_i   = 32'h1111_1111;
      tick();
      bus.inst_valid_i = 1'b0;
      chk("illegal_pulse", 64'(bus.illegal_o), 64'd1);
      chk("illegal_inst_ready", 64'(bus.inst_ready_o), 64'd1);
      chk("illegal_res_valid", 64'(bus.res_valid_o), 64'd0);
      chk("illegal_ctrl_kept", 64'(bus.ALU_control_o), 64'(ctrl0));
      chk("illegal_data1_kept", 64'(bus.data1_o), 64'(d1_0));
      tick();
      chk("illegal_pulse_end", 64'(bus.illegal_o), 64'd0);
      chk("illegal_res_valid2", 64'(bus.res_valid_o), 64'd0);
   endtask

   task automatic chk_zero_state(input string tag);
      chk({tag, "_inst_ready"}, 64'(bus.inst_ready_o), 64'd1);
      chk({tag, "_res_valid"}, 64'(bus.res_valid_o), 64'd0);
      chk({tag, "_illegal"}, 64'(bus.illegal_o), 64'd0);
      chk({tag, "_ctrl"}, 64'(bus.ALU_control_o), 64'd0);
      chk({tag, "_data1"}, 64'(bus.data1_o), 64'd0);
      chk({tag, "_data2"}, 64'(bus.data2_o), 64'd0);
      chk({tag, "_result"}, 64'(bus.result_o), 64'd0);
      chk({tag, "_rd"}, 64'(bus.rd_addr_o), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.inst_valid_i = 1'b0;
      bus.inst_i       = '0;
      bus.rs1_data_i   = '0;
      bus.rs2_data_i   = '0;
      bus.res_ready_i  = 1'b0;
      tick();
      tick();
      chk_zero_state("reset");
      rst_n = 1'b1;
      tick();

      // Reset during a MUL in EXEC abandons it.
      wait_ready();
      bus.inst_valid_i = 1'b1;
      bus.inst_i       = 32'h022082B3;
      bus.rs1_data_i   = 32'h0001_0000;
      bus.rs2_data_i   = 32'h0001_0001;
      tick();
      bus.inst_valid_i = 1'b0;
      tick();
      chk("mid_mul_ctrl", 64'(bus.ALU_control_o), 64'd2);
      rst_n = 1'b0;
      #1;
      chk_zero_state("midreset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      issue(32'h002081B3, 32'd5, 32'd7, 3'b000, 32'd7, 32'd12, 1, 0);
      issue(32'h40208233, 32'd3, 32'd5, 3'b001, 32'd5, 32'hFFFF_FFFE, 1, 4);
      issue(32'h022082B3, 32'h0001_0000, 32'h0001_0001, 3'b010, 32'h0001_0001, 32'h0001_0000, 3, 0);
      issue(32'hFFF08313, 32'd0, 32'h0000_1234, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
      issue(32'h0F00F393, 32'h0000_00FF, 32'h0000_1234, 3'b101, 32'h0000_00F0, 32'h0000_00F0, 1, 0);
      issue(32'h0020E433, 32'h0000_F0F0, 32'h0000_0F00, 3'b100, 32'h0000_0F00, 32'h0000_FFF0, 1, 1);
      issue(32'h0020F4B3, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b101, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
      issue(32'h8000E513, 32'h0000_0005, 32'h0, 3'b100, 32'hFFFF_F800, 32'hFFFF_F805, 1, 0);
      issue(32'h022085B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 3, 2);
      issue(32'h00208033, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0001, 32'h0, 1, 0);

      issue_illegal(32'h0000A0B3);
      issue_illegal(32'h0020C0B3);
      issue_illegal(32'h4020D0B3);
      issue_illegal(32'h00208037);

      issue(32'h002081B3, 32'd100, 32'd23, 3'b000, 32'd23, 32'd123, 1, 0);

      tick();
      tick();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencer on the driving side of the 3-bit ALU control interface. It accepts one decoded-register-read instruction at a time (RISC-V add/sub/mul/or/and/addi/ori/andi) over a valid/ready handshake. It translates funct/opcode fields into the ALU control code, drives the ALU operands, and waits a fixed number of cycles before capturing the ALU result (multi-cycle for MUL). It then presents the result plus destination register to writeback over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width
MUL_LATENCY, 3, cycles the ALU inputs are held stable for MUL before capture; values below 1 behave as 1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
inst_valid_i  in  1  instruction + operands valid
inst_ready_o  out  1  block can accept an instruction
inst_i  in  32  instruction word
rs1_data_i  in  DATA_WIDTH  rs1 register value
rs2_data_i  in  DATA_WIDTH  rs2 register value
ALU_control_o  out  3  ALU control code (ADD 000, SUB 001, MUL 010, OR 100, AND 101)
data1_o  out  DATA_WIDTH  ALU operand 1
data2_o  out  DATA_WIDTH  ALU operand 2
result_i  in  DATA_WIDTH  combinational ALU result
res_valid_o  out  1  result available
res_ready_i  in  1  writeback accepts result
result_o  out  DATA_WIDTH  captured result
rd_addr_o  out  5  destination register, inst[11:7]
illegal_o  out  1  one-cycle pulse: rejected instruction

Behaviour:
- Reset (rst_i low, async): state IDLE, inst_ready_o=1, res_valid_o=0, illegal_o=0, ALU_control_o=000, data1_o/data2_o/result_o=0, rd_addr_o=0, counter=0. Reset asserted mid-operation abandons the instruction; no result is ever presented for it.
- States: IDLE, EXEC, DONE. inst_ready_o=1 only in IDLE. res_valid_o=1 only in DONE.
- Decode on opcode inst[6:0], funct3 inst[14:12], funct7 inst[31:25]:
  - 0110011: funct7 0000000/funct3 000 -> ADD; 0100000/000 -> SUB; 0000001/000 -> MUL; 0000000/110 -> OR; 0000000/111 -> AND. data2 = rs2_data_i.
  - 0010011: funct3 000 -> ADD (addi); 110 -> OR (ori); 111 -> AND (andi). data2 = sign-extended inst[31:20].
  - All other encodings are illegal.
- IDLE: handshake is inst_valid_i & inst_ready_o at a rising edge.
  - Legal instruction: register the control code, data1_o=rs1_data_i, data2_o, and rd_addr_o; go to EXEC; load counter with 1 (non-MUL) or MUL_LATENCY (MUL).
  - Illegal instruction: illegal_o=1 for exactly the next cycle; stay in IDLE; ALU outputs unchanged; no result.
- EXEC: ALU_control_o, data1_o and data2_o are held stable. The counter decrements each edge. On the edge where the counter equals 1, result_o<=result_i and the state goes to DONE.
- Latency: accept at edge t0; capture at edge t0+1 (non-MUL) or t0+MUL_LATENCY (MUL). res_valid_o is high from that edge onward.
- DONE: result_o and rd_addr_o are held. res_valid_o stays 1 until res_ready_i=1 at an edge; then go to IDLE (inst_ready_o=1 next cycle). A new instruction cannot be accepted in the same cycle as result acceptance.
- inst_valid_i while inst_ready_o=0 is ignored; upstream must hold it.
- ALU_control_o/data*_o retain their last values in IDLE/DONE (no glitching back to 0).
- Arithmetic is done by the external ALU; wrap-around is modulo 2^DATA_WIDTH, and MUL returns the low DATA_WIDTH bits. The block never modifies result_i.
- rd=x0 is passed through unchanged; suppression is writeback's job.

Test Plan:
- Reset mid-MUL: assert rst_i low during EXEC -> res_valid_o=0, inst_ready_o=1, outputs 0 immediately; after release, add is accepted normally.
- add x3,x1,x2 (inst 0x002081B3), rs1=5, rs2=7, res_ready_i=1 -> ALU_control_o=000, res_valid_o high 1 cycle after accept, result_o=12, rd_addr_o=3.
- sub x4,x1,x2 (0x40208233), rs1=3, rs2=5 -> ALU_control_o=001, result_o=0xFFFFFFFE; hold res_ready_i=0 for 4 cycles -> result_o stable, inst_ready_o=0; inst_valid_i pulses meanwhile are ignored.
- mul x5,x1,x2 (0x022082B3), rs1=0x10000, rs2=0x10001, MUL_LATENCY=3 -> control 010 held 3 cycles, capture at t0+3, result_o=0x00010000.
- addi x6,x1,-1 (0xFFF08313), rs1=0 -> data2_o=0xFFFFFFFF, result_o=0xFFFFFFFF; andi x7,x1,0x0F0 with rs1=0xFF -> control 101, result 0xF0.
- Illegal 0x0000A0B3 (funct3 010 R-type) -> illegal_o high exactly 1 cycle, res_valid_o stays 0, inst_ready_o stays 1.
